// File: rtl/safe_mode_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : safe_mode_seq_pkg
// Brief    : Shared state/config types and core-mask helper for the
//            safe-mode sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package safe_mode_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HALT   = 3'd1,
      SYNC   = 3'd2,
      RESUME = 3'd3,
      RUN    = 3'd4,
      DEACT  = 3'd5,
      ERR    = 3'd6
   } seq_state_e;

   typedef enum logic [1:0] {
      CFG_TMR    = 2'd0,
      CFG_DMR    = 2'd1,
      CFG_SINGLE = 2'd2,
      CFG_RSVD   = 2'd3
   } seq_cfg_e;

   // DMR pairs the master with its left neighbour (bit 2 wraps to bit 0).
   function automatic logic [2:0] core_mask(input logic [1:0] cfg, input logic [2:0] master);
      logic [2:0] mask;
      mask = master;
      if (cfg == CFG_TMR) begin
         mask = 3'b111;
      end else if (cfg == CFG_DMR) begin
         mask = master | {master[1:0], master[2]};
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/safe_seq_timeout.sv
`default_nettype none
// ============================================================================
// Module   : safe_seq_timeout
// Brief    : Saturating acknowledge-timeout counter; expires at
//            TIMEOUT_CYCLES-1 counts since the last clear.
// Revision : 1.0 - initial release
// ============================================================================
module safe_seq_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int               c_cnt_w = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

   logic [c_cnt_w-1:0] r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != c_last)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/safe_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : safe_mode_sequencer
// Brief    : Halts, syncs and releases the three-core cluster on a safe-mode
//            switch. Define SAFE_SEQ_TIMEOUT_EN to enable ack timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module safe_mode_sequencer
   import safe_mode_seq_pkg::*;
#(
   parameter int NCORES         = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       safe_mode_i,
   input  logic [1:0] safe_configuration_i,
   input  logic [2:0] master_core_i,
   input  logic       initial_sync_master_i,
   input  logic       end_sw_routine_i,
   input  logic [2:0] core_debug_mode_i,
   output logic [2:0] debug_req_o,
   output logic       tmr_en_o,
   output logic       dmr_en_o,
   output logic [2:0] active_mask_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o
);

   if ((NCORES != 3) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
      $error("safe_mode_sequencer: NCORES must be 3 and TIMEOUT_CYCLES >= 2");
   end

   seq_state_e r_state, w_state_d;
   logic       r_start_q, r_end_q;
   logic [2:0] r_mask_q, r_halt_mask_q;
   logic [1:0] r_cfg_q;
   logic       w_start_rise, w_end_rise, w_cfg_valid, w_latch, w_expired;
   logic [2:0] w_new_mask, w_new_halt, w_mask_d, w_halt_mask_d, w_dbg_d, w_act_d;
   logic [1:0] w_cfg_d;
   logic       w_tmr_d, w_dmr_d, w_busy_d, w_done_d, w_err_d;

   assign w_start_rise = start_i & ~r_start_q;
   assign w_end_rise   = end_sw_routine_i & ~r_end_q;
   assign w_cfg_valid  = (safe_configuration_i != CFG_RSVD) && $onehot(master_core_i);
   assign w_new_mask   = core_mask(safe_configuration_i, master_core_i);
   assign w_new_halt   = initial_sync_master_i ? (w_new_mask & ~master_core_i) : w_new_mask;

`ifdef SAFE_SEQ_TIMEOUT_EN
   logic w_state_chg;
   assign w_state_chg = (w_state_d != r_state);

   safe_seq_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .i_clear   (w_state_chg),
      .i_enable  ((r_state == HALT) || (r_state == RESUME)),
      .o_expired (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_latch   = 1'b0;
      case (r_state)
         IDLE, RUN: begin
            if (w_start_rise) begin
               if (!safe_mode_i) begin
                  w_state_d = DEACT;
               end else if (!w_cfg_valid) begin
                  w_state_d = ERR;
               end else begin
                  w_state_d = HALT;
                  w_latch   = 1'b1;
               end
            end
         end
         // Acknowledge is tested before expiry so a same-cycle ack wins.
         HALT: begin
            if ((core_debug_mode_i & r_halt_mask_q) == r_halt_mask_q) begin
               w_state_d = SYNC;
            end else if (w_expired) begin
               w_state_d = ERR;
            end
         end
         SYNC: begin
            if (w_end_rise) begin
               w_state_d = RESUME;
            end
         end
         RESUME: begin
            if ((core_debug_mode_i & r_halt_mask_q) == 3'b000) begin
               w_state_d = RUN;
            end else if (w_expired) begin
               w_state_d = ERR;
            end
         end
         DEACT, ERR: w_state_d = IDLE;
         default:    w_state_d = IDLE;
      endcase

      w_mask_d      = w_latch ? w_new_mask           : r_mask_q;
      w_halt_mask_d = w_latch ? w_new_halt           : r_halt_mask_q;
      w_cfg_d       = w_latch ? safe_configuration_i : r_cfg_q;

      // Outputs are computed from the next state so every port is a flop.
      w_dbg_d = ((w_state_d == HALT) || (w_state_d == SYNC)) ? w_halt_mask_d : 3'b000;
      w_act_d = active_mask_o;
      w_tmr_d = tmr_en_o;
      w_dmr_d = dmr_en_o;
      if (w_state_d == RUN) begin
         w_act_d = w_mask_d;
         w_tmr_d = (w_cfg_d == CFG_TMR);
         w_dmr_d = (w_cfg_d == CFG_DMR);
      end else if ((w_state_d == DEACT) || (w_state_d == ERR)) begin
         w_act_d = 3'b000;
         w_tmr_d = 1'b0;
         w_dmr_d = 1'b0;
      end
      w_done_d = ((w_state_d == RUN) && (r_state != RUN)) || (w_state_d == DEACT);
      w_err_d  = (w_state_d == ERR);
      w_busy_d = !((w_state_d == IDLE) || (w_state_d == RUN));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_start_q     <= 1'b0;
         r_end_q       <= 1'b0;
         r_mask_q      <= 3'b000;
         r_halt_mask_q <= 3'b000;
         r_cfg_q       <= 2'b00;
         debug_req_o   <= 3'b000;
         tmr_en_o      <= 1'b0;
         dmr_en_o      <= 1'b0;
         active_mask_o <= 3'b000;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         error_o       <= 1'b0;
      end else begin
         r_start_q     <= start_i;
         r_end_q       <= end_sw_routine_i;
         r_mask_q      <= w_mask_d;
         r_halt_mask_q <= w_halt_mask_d;
         r_cfg_q       <= w_cfg_d;
         debug_req_o   <= w_dbg_d;
         tmr_en_o      <= w_tmr_d;
         dmr_en_o      <= w_dmr_d;
         active_mask_o <= w_act_d;
         busy_o        <= w_busy_d;
         done_o        <= w_done_d;
         error_o       <= w_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_safe_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_safe_mode_sequencer
// Brief    : Randomized self-checking bench for safe_mode_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_safe_mode_sequencer;

   localparam int TO = 16;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       start_i = 1'b0;
   logic       safe_mode_i = 1'b0;
   logic [1:0] safe_configuration_i = 2'd0;
   logic [2:0] master_core_i = 3'b001;
   logic       initial_sync_master_i = 1'b0;
   logic       end_sw_routine_i = 1'b0;
   logic [2:0] core_debug_mode_i = 3'b000;
   logic [2:0] debug_req_o;
   logic       tmr_en_o, dmr_en_o;
   logic [2:0] active_mask_o;
   logic       busy_o, done_o, error_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected persistent mode outputs (what the last RUN established).
   logic [2:0] m_act = 3'b000;
   logic       m_tmr = 1'b0;
   logic       m_dmr = 1'b0;

   safe_mode_sequencer #(
      .NCORES         (3),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .start_i               (start_i),
      .safe_mode_i           (safe_mode_i),
      .safe_configuration_i  (safe_configuration_i),
      .master_core_i         (master_core_i),
      .initial_sync_master_i (initial_sync_master_i),
      .end_sw_routine_i      (end_sw_routine_i),
      .core_debug_mode_i     (core_debug_mode_i),
      .debug_req_o           (debug_req_o),
      .tmr_en_o              (tmr_en_o),
      .dmr_en_o              (dmr_en_o),
      .active_mask_o         (active_mask_o),
      .busy_o                (busy_o),
      .done_o                (done_o),
      .error_o               (error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_all(input string tag, input logic [2:0] dbg, input logic busy,
                             input logic done, input logic err);
      check_eq({tag, ".debug_req"}, 32'(debug_req_o), 32'(dbg));
      check_eq({tag, ".tmr_en"}, 32'(tmr_en_o), 32'(m_tmr));
      check_eq({tag, ".dmr_en"}, 32'(dmr_en_o), 32'(m_dmr));
      check_eq({tag, ".active_mask"}, 32'(active_mask_o), 32'(m_act));
      check_eq({tag, ".busy"}, 32'(busy_o), 32'(busy));
      check_eq({tag, ".done"}, 32'(done_o), 32'(done));
      check_eq({tag, ".error"}, 32'(error_o), 32'(err));
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Reference participation set from the master's core index.
   function automatic logic [2:0] ref_mask(input int cfg, input int midx);
      int m;
      if (cfg == 0) m = 7;
      else if (cfg == 1) m = (1 << midx) | (1 << ((midx + 1) % 3));
      else m = 1 << midx;
      return 3'(m);
   endfunction

   task automatic run_seq(input int cfg, input int midx, input bit isync,
                          input int ack_dly, input int rel_dly, input bit end_early);
      logic [2:0] mask, hm, master, noise;
      int         rd;
      master = 3'(1 << midx);
      mask   = ref_mask(cfg, midx);
      hm     = isync ? (mask & ~master) : mask;
      rd     = (hm == 3'b000) ? 0 : rel_dly;
      safe_mode_i           = 1'b1;
      safe_configuration_i  = 2'(cfg);
      master_core_i         = master;
      initial_sync_master_i = isync;
      start_i               = 1'b1;
      step();
      start_i = 1'b0;
      expect_all("halt_entry", hm, 1'b1, 1'b0, 1'b0);
      noise             = 3'($urandom) & ~hm;
      core_debug_mode_i = noise;
      if (end_early) end_sw_routine_i = 1'b1;
      repeat (ack_dly) begin
         step();
         expect_all("halt_wait", hm, 1'b1, 1'b0, 1'b0);
      end
      core_debug_mode_i = hm | noise;
      step();
      expect_all("sync_entry", hm, 1'b1, 1'b0, 1'b0);
      safe_configuration_i  = 2'($urandom);
      master_core_i         = 3'($urandom);
      initial_sync_master_i = 1'($urandom);
      if (end_early) begin
         end_sw_routine_i = 1'b0;
         step();
         expect_all("sync_after_early_end", hm, 1'b1, 1'b0, 1'b0);
      end
      repeat ($urandom_range(0, 3)) begin
         step();
         expect_all("sync_hold", hm, 1'b1, 1'b0, 1'b0);
      end
      end_sw_routine_i = 1'b1;
      step();
      expect_all("resume_entry", 3'b000, 1'b1, 1'b0, 1'b0);
      repeat (rd) begin
         step();
         expect_all("resume_wait", 3'b000, 1'b1, 1'b0, 1'b0);
      end
      core_debug_mode_i = noise;
      step();
      m_act = mask;
      m_tmr = (cfg == 0);
      m_dmr = (cfg == 1);
      expect_all("run_entry", 3'b000, 1'b0, 1'b1, 1'b0);
      end_sw_routine_i  = 1'b0;
      core_debug_mode_i = 3'($urandom);
      step();
      expect_all("run_hold", 3'b000, 1'b0, 1'b0, 1'b0);
      core_debug_mode_i = 3'b000;
   endtask

   task automatic deact();
      safe_mode_i = 1'b0;
      start_i     = 1'b1;
      step();
      start_i = 1'b0;
      m_act = 3'b000;
      m_tmr = 1'b0;
      m_dmr = 1'b0;
      expect_all("deact", 3'b000, 1'b1, 1'b1, 1'b0);
      step();
      expect_all("deact_idle", 3'b000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic bad_cfg(input logic [1:0] cfg, input logic [2:0] master);
      safe_mode_i           = 1'b1;
      safe_configuration_i  = cfg;
      master_core_i         = master;
      initial_sync_master_i = 1'($urandom);
      start_i               = 1'b1;
      step();
      start_i = 1'b0;
      m_act = 3'b000;
      m_tmr = 1'b0;
      m_dmr = 1'b0;
      expect_all("bad_cfg", 3'b000, 1'b1, 1'b0, 1'b1);
      step();
      expect_all("bad_cfg_idle", 3'b000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_noise();
      safe_mode_i           = 1'($urandom);
      safe_configuration_i  = 2'($urandom);
      master_core_i         = 3'($urandom);
      initial_sync_master_i = 1'($urandom);
      core_debug_mode_i     = 3'($urandom);
      end_sw_routine_i      = 1'($urandom);
      step();
      expect_all("quiet", 3'b000, 1'b0, 1'b0, 1'b0);
      end_sw_routine_i  = 1'b0;
      core_debug_mode_i = 3'b000;
      step();
      expect_all("quiet_end", 3'b000, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int         op;
      logic [2:0] bm;
      step();
      step();
      expect_all("reset", 3'b000, 1'b0, 1'b0, 1'b0);
      rst_ni = 1'b1;
      step();
      expect_all("idle", 3'b000, 1'b0, 1'b0, 1'b0);

      run_seq(0, 0, 1'b0, 5, 2, 1'b0);
      run_seq(1, 2, 1'b1, 3, 1, 1'b0);
      deact();
      bad_cfg(2'd3, 3'b001);
      bad_cfg(2'd0, 3'b011);
      run_seq(2, 1, 1'b1, 0, 0, 1'b0);
      run_seq(0, 1, 1'b0, 2, 2, 1'b1);
      bad_cfg(2'd1, 3'b000);

      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 9);
         if (op <= 5) begin
            run_seq($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         end else if (op == 6) begin
            deact();
         end else if (op == 7) begin
            if ($urandom_range(0, 1) == 1) begin
               bad_cfg(2'd3, 3'($urandom));
            end else begin
               do bm = 3'($urandom); while ($onehot(bm));
               bad_cfg(2'($urandom_range(0, 2)), bm);
            end
         end else begin
            idle_noise();
         end
      end
      deact();

`ifdef SAFE_SEQ_TIMEOUT_EN
      safe_mode_i           = 1'b1;
      safe_configuration_i  = 2'd0;
      master_core_i         = 3'b001;
      initial_sync_master_i = 1'b0;
      start_i               = 1'b1;
      step();
      start_i           = 1'b0;
      core_debug_mode_i = 3'b011;
      expect_all("to_halt", 3'b111, 1'b1, 1'b0, 1'b0);
      repeat (TO - 1) begin
         step();
         expect_all("to_wait", 3'b111, 1'b1, 1'b0, 1'b0);
      end
      step();
      expect_all("to_err", 3'b000, 1'b1, 1'b0, 1'b1);
      core_debug_mode_i = 3'b000;
      step();
      expect_all("to_idle", 3'b000, 1'b0, 1'b0, 1'b0);

      start_i = 1'b1;
      step();
      start_i           = 1'b0;
      core_debug_mode_i = 3'b011;
      repeat (TO - 1) step();
      expect_all("race_last", 3'b111, 1'b1, 1'b0, 1'b0);
      core_debug_mode_i = 3'b111;
      step();
      expect_all("race_sync", 3'b111, 1'b1, 1'b0, 1'b0);
      end_sw_routine_i = 1'b1;
      step();
      core_debug_mode_i = 3'b000;
      step();
      m_act = 3'b111;
      m_tmr = 1'b1;
      m_dmr = 1'b0;
      expect_all("race_run", 3'b000, 1'b0, 1'b1, 1'b0);
      end_sw_routine_i = 1'b0;
      step();
      deact();
`endif

      run_seq(0, 0, 1'b0, 1, 1, 1'b0);
      deact();
      check_eq("deact_tmr_off", 32'(tmr_en_o), 32'd0);

      safe_mode_i           = 1'b1;
      safe_configuration_i  = 2'd0;
      master_core_i         = 3'b001;
      initial_sync_master_i = 1'b0;
      start_i               = 1'b1;
      step();
      start_i           = 1'b0;
      core_debug_mode_i = 3'b111;
      step();
      expect_all("rst_sync", 3'b111, 1'b1, 1'b0, 1'b0);
      #3;
      rst_ni = 1'b0;
      #1;
      m_act = 3'b000;
      m_tmr = 1'b0;
      m_dmr = 1'b0;
      expect_all("async_rst", 3'b000, 1'b0, 1'b0, 1'b0);
      core_debug_mode_i = 3'b000;
      step();
      rst_ni = 1'b1;
      step();
      expect_all("post_rst", 3'b000, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/safe_mode_sequencer.md
Name: safe_mode_sequencer

Overview:
- Consumes the safe-mode configuration levels from the safe-wrapper control registers: start, safe_mode, configuration, master core, initial-sync, end-of-SW-routine.
- Sequences a mode switch on the three-core cluster: halts the participating cores via debug request, waits for halt acknowledge, holds them while the sync SW routine runs, then releases them and asserts the mode-enable outputs.
- Emits one-cycle done/error pulses that firmware or the control block uses to clear start.

Parameters:
- NCORES, 3, number of cores; fixed at 3, other values unsupported.
- TIMEOUT_CYCLES, 1024, halt/resume acknowledge timeout in clk_i cycles, must be ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start level from control register.
- safe_mode_i  in  1  safe mode requested.
- safe_configuration_i  in  2  0=TMR, 1=DMR, 2=SINGLE, 3=reserved.
- master_core_i  in  3  one-hot master core select.
- initial_sync_master_i  in  1  1: master is not halted during sync.
- end_sw_routine_i  in  1  end-of-sync-routine level.
- core_debug_mode_i  in  3  per-core "in debug/halted" acknowledge.
- debug_req_o  out  3  per-core halt request, level.
- tmr_en_o  out  1  TMR mode active.
- dmr_en_o  out  1  DMR mode active.
- active_mask_o  out  3  cores participating in the current mode.
- busy_o  out  1  FSM not in IDLE or RUN.
- done_o  out  1  one-cycle pulse on entering RUN.
- error_o  out  1  one-cycle pulse on bad config or timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; edge registers 0; timeout counter 0.
- Edge detection: start_q and end_q registers. start_rise = start_i & ~start_q; end_rise = end_sw_routine_i & ~end_q.
- Participating mask, combinational:
  - TMR: 3'b111.
  - DMR: master | rotl1(master), e.g. master 3'b100 gives 3'b101.
  - SINGLE: master.
- halt_mask = mask & ~master when initial_sync_master_i=1, otherwise mask.
- Config is valid when safe_configuration_i != 3 and $onehot(master_core_i).
- States and transitions:
  - IDLE: on start_rise & safe_mode_i:
    - if config invalid -> ERR;
    - else latch mask and halt_mask into registers (used thereafter; later input changes ignored) -> HALT.
    - start_rise with safe_mode_i=0 -> DEACT.
  - HALT: debug_req_o = halt_mask_q. When (core_debug_mode_i & halt_mask_q) == halt_mask_q -> SYNC. Timeout -> ERR. An empty halt_mask (SINGLE with initial_sync_master_i=1) passes through HALT in 1 cycle.
  - SYNC: debug_req_o held. end_rise -> RESUME. No timeout.
  - RESUME: debug_req_o = 0. When (core_debug_mode_i & halt_mask_q) == 0 -> RUN. Timeout -> ERR.
  - RUN:
    - active_mask_o = mask_q; tmr_en_o = (cfg_q==TMR); dmr_en_o = (cfg_q==DMR).
    - done_o pulses exactly in the first RUN cycle.
    - start_rise with safe_mode_i=1 -> re-sequence: outputs stay until new RUN.
    - start_rise with safe_mode_i=0 -> DEACT.
  - DEACT: clear tmr_en_o, dmr_en_o and active_mask_o in 1 cycle; pulse done_o -> IDLE.
  - ERR: debug_req_o = 0, error_o pulses for 1 cycle, mode outputs cleared -> IDLE.
- Latency: start_rise at cycle N gives HALT with debug_req_o visible at N+1. All outputs are registered.
- Timeout counter:
  - cleared on every state change;
  - counts in HALT and RESUME;
  - expires when count == TIMEOUT_CYCLES-1;
  - saturates, no wrap.
- Simultaneous events: ack and timeout in the same cycle resolve as ack wins. end_rise during HALT is ignored (not stored).
- Async reset mid-sequence drops debug_req_o immediately.

Optional Feature:
- Macro SAFE_SEQ_TIMEOUT_EN.
- Defined: timeout counter instantiated; HALT/RESUME go to ERR on expiry.
- Undefined: no counter; HALT/RESUME wait indefinitely; error_o only from invalid config.

Decomposition:
- Package safe_mode_seq_pkg:
  - state enum (IDLE, HALT, SYNC, RESUME, RUN, DEACT, ERR);
  - config enum (CFG_TMR=2'd0, CFG_DMR=2'd1, CFG_SINGLE=2'd2);
  - function core_mask(cfg, master).
- One sub-module safe_seq_timeout: clear, enable, expired; counter width $clog2(TIMEOUT_CYCLES). Instantiated only under SAFE_SEQ_TIMEOUT_EN.

Test Plan:
- TMR, master 3'b001, initial_sync 0; start rise; acks 3'b111 after 5 cycles.
  - Expected: debug_req 3'b111 at N+1; SYNC.
  - Then end_rise; acks drop; expected: done_o 1 pulse, tmr_en_o=1, active_mask_o=3'b111.
- DMR, master 3'b100, initial_sync 1.
  - Expected: mask 3'b101, debug_req 3'b001.
  - After release, expected: dmr_en_o=1, active_mask_o=3'b101.
- Invalid config:
  - cfg=3 -> error_o pulse, all outputs 0, back to IDLE.
  - master=3'b011 -> error_o pulse, all outputs 0, back to IDLE.
- SAFE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, core 2 never acks in HALT.
  - Expected: error_o exactly 16 cycles after HALT entry; debug_req_o=0.
  - Ack and expiry in the same cycle: expected SYNC.
- From RUN (TMR), start rise with safe_mode_i=0.
  - Expected: tmr_en_o=0, done_o pulse, IDLE.
  - rst_ni asserted during SYNC: expected debug_req_o=0 asynchronously.
